des_round_ctrl: RTL and testbench
=================================

# des_round_ctrl

Sequencer for the iterative DES core: accepts one 64-bit block request, then steps the shared round datapath (E-expansion, key XOR, S-box bank s1..s8, P-permutation, L/R swap) once per cycle for NUM_ROUNDS rounds. Alongside the data strobes it drives the key-schedule rotation controls. It then strobes the final swap/FP stage and holds the result under a valid/ready output handshake. It contains no data bits: only FSM, round counter and schedule decode.

## Interface
Parameters:
- NUM_ROUNDS, 16, rounds per block; legal 1..16. Values other than 16 are for reduced-round bring-up only.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  controller can accept a request.
- in_decrypt  in  1  mode for the request (1 = decrypt); sampled on accept.
- ld_en  out  1  datapath loads IP(data) into L/R and PC-1(key) into C/D this cycle.
- rnd_en  out  1  datapath executes one round this cycle.
- rnd_idx  out  4  index of the current round, 0..NUM_ROUNDS-1.
- key_shift  out  2  C/D rotate amount for this round's subkey: 0, 1 or 2.
- key_dir  out  1  rotate direction (0 = left/encrypt, 1 = right/decrypt).
- fin_en  out  1  datapath applies the final R/L swap and FP into the output register.
- out_valid  out  1  result register holds a completed block.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, the request is accepted: ld_en=1 the same cycle (combinational), mode is latched, rnd_idx is cleared, and the next state is ROUND.
  - ROUND: rnd_en=1. rnd_idx increments each cycle. After rnd_idx==NUM_ROUNDS-1, the next state is FINAL.
  - FINAL: fin_en=1 for exactly one cycle; the next state is OUT.
  - OUT: out_valid=1 and held until out_ready=1; then the next state is IDLE.
- in_ready=0 in ROUND, FINAL and OUT. There is no overlap between blocks.
- Shift schedule, encryption: key_dir=0; key_shift = ENC_SHIFT[rnd_idx] with ENC_SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Shift schedule, decryption: key_dir=1; key_shift = DEC_SHIFT[rnd_idx] with DEC_SHIFT = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- The datapath rotates C/D by key_shift in the key_dir direction in the rnd_en cycle and uses the rotated value for that round's subkey.
- Outside ROUND, key_shift=0 and key_dir holds the latched mode.
- The mode latch changes only on accept. A change of in_decrypt mid-block has no effect.
- rnd_en, ld_en and fin_en are mutually exclusive in every cycle.
- out_valid may be held indefinitely. While held, no other strobe asserts.

## Timing
- Reset: while rst=1 at a clock edge, the next state is IDLE, rnd_idx=0 and the mode latch=0. In the cycle after reset:
  - in_ready=1, busy=0;
  - ld_en, rnd_en, fin_en, out_valid, key_shift, key_dir all 0 (ld_en follows in_valid).
- Reset mid-block aborts the block without fin_en or out_valid. The datapath contents are don't-care.
- Latency: accept edge at cycle T gives rnd_en in cycles T+1..T+NUM_ROUNDS, fin_en at T+NUM_ROUNDS+1, and out_valid from T+NUM_ROUNDS+2.
- Minimum block period is NUM_ROUNDS+3 cycles, including 1 IDLE cycle.
- in_valid=1 while out_valid=1 is not accepted; it waits until IDLE.
- out_ready=1 with out_valid=0 is ignored.
- rnd_idx does not wrap past NUM_ROUNDS-1; it holds its last value until the next accept.

## Structure
- Package des_pkg holds:
  - state enum (IDLE, ROUND, FINAL, OUT);
  - ENC_SHIFT and DEC_SHIFT as 16-entry 2-bit constant arrays;
  - widths for rnd_idx and key_shift.
- Optional sub-module des_shift_sched: combinational decode of (rnd_idx, decrypt) to key_shift. Otherwise everything is one module.

## Test plan
- Reset, then idle: hold rst for 2 cycles with in_valid=0 → in_ready=1, busy=0, all strobes 0 for 10 cycles.
- Encrypt one block with out_ready=1, accept at cycle 0:
  - ld_en at cycle 0;
  - rnd_en at cycles 1..16 with rnd_idx 0..15;
  - key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 with key_dir=0;
  - fin_en at cycle 17, out_valid at cycle 18, in_ready at cycle 19.
- Decrypt one block → key_dir=1 and key_shift sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held 1:
  - out_valid stays high and no strobes assert;
  - after out_ready=1, the next accept follows 1 cycle later.
- Reset at the rnd_idx=7 cycle → no fin_en and no out_valid; IDLE (in_ready=1) in the next cycle.
- With the datapath attached, encrypt key 133457799BBCDFF1, plaintext 0123456789ABCDEF → 85E813540F0AB405.
- Decrypt of 85E813540F0AB405 with the same key → 0123456789ABCDEF.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types, widths and key-rotation schedules for the DES round sequencer
package des_pkg;

    localparam int RND_IDX_W   = 4;
    localparam int KEY_SHIFT_W = 2;

    typedef logic [RND_IDX_W-1:0]   rnd_idx_t;
    typedef logic [KEY_SHIFT_W-1:0] key_shift_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Decrypt starts with a zero shift: C0/D0 after the full 28-bit rotation already yields K16.
    localparam key_shift_t ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam key_shift_t DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_round_ctrl_if.sv
// rtl/des_round_ctrl_if.sv - request, datapath strobe and result handshake bundle of the round sequencer
interface des_round_ctrl_if;
    import des_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       in_decrypt;
    logic       ld_en;
    logic       rnd_en;
    rnd_idx_t   rnd_idx;
    key_shift_t key_shift;
    logic       key_dir;
    logic       fin_en;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    // master: the sequencer; slave: requester, consumer and datapath side
    modport master (
        input  in_valid, in_decrypt, out_ready,
        output in_ready, ld_en, rnd_en, rnd_idx, key_shift, key_dir,
               fin_en, out_valid, busy
    );

    modport slave (
        output in_valid, in_decrypt, out_ready,
        input  in_ready, ld_en, rnd_en, rnd_idx, key_shift, key_dir,
               fin_en, out_valid, busy
    );

endinterface

// File: rtl/des_shift_sched.sv
// rtl/des_shift_sched.sv - combinational decode of round index and mode to the C/D rotate amount
module des_shift_sched
    import des_pkg::*;
(
    input  rnd_idx_t   rnd_idx,
    input  logic       decrypt,
    output key_shift_t key_shift
);

    assign key_shift = decrypt ? DEC_SHIFT[rnd_idx] : ENC_SHIFT[rnd_idx];

endmodule

// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - sequencer that loads, iterates, finalises and hands off one DES block at a time
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic           clk,
    input  logic           rst,
    des_round_ctrl_if.master bus
);

    localparam rnd_idx_t LAST_IDX = rnd_idx_t'(NUM_ROUNDS - 1);

    state_t     state_q, state_d;
    rnd_idx_t   idx_q, idx_d;
    logic       mode_q, mode_d;
    key_shift_t sched_shift;

    des_shift_sched u_sched (
        .rnd_idx   (idx_q),
        .decrypt   (mode_q),
        .key_shift (sched_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        bus.in_ready  = 1'b0;
        bus.ld_en     = 1'b0;
        bus.rnd_en    = 1'b0;
        bus.fin_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.key_shift = '0;

        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ld_en = 1'b1;
                    mode_d    = bus.in_decrypt;
                    idx_d     = '0;
                    state_d   = ROUND;
                end
            end
            ROUND: begin
                bus.rnd_en    = 1'b1;
                bus.key_shift = sched_shift;
                // The index parks on the last round so the datapath sees a stable value afterwards.
                if (idx_q == LAST_IDX) begin
                    state_d = FINAL;
                end else begin
                    idx_d = idx_q + rnd_idx_t'(1);
                end
            end
            FINAL: begin
                bus.fin_en = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rnd_idx = idx_q;
    assign bus.key_dir = mode_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb/tb_des_round_ctrl.sv - self-checking bench: cycle-timeline reference model plus a behavioural DES datapath
module tb_des_round_ctrl;

    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_round_ctrl_if bus_if ();

    des_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int errors = 0;
    int checks = 0;

    int enc_tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_tbl [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                       10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5,  3,28,15,6,21,10,  23,19,12,4,26,8,  16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [63:0] ip_fn(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[63-i] = v[64-IP_T[i]];
        return o;
    endfunction

    function automatic logic [63:0] fp_fn(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 64; i++) o[64-IP_T[i]] = v[63-i];
        return o;
    endfunction

    function automatic logic [55:0] pc1_fn(input logic [63:0] v);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = v[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2_fn(input logic [55:0] v);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = v[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [27:0] rot_fn(input logic [27:0] v, input int n, input bit right);
        logic [27:0] o;
        o = v;
        for (int i = 0; i < n; i++) o = right ? {o[0], o[27:1]} : {o[26:0], o[27]};
        return o;
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  six;
        int row, col;
        for (int i = 0; i < 48; i++) x[47-i] = r[32 - (((4*(i/6) + (i%6) - 1 + 32) % 32) + 1)];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            six = x[47-6*j -: 6];
            row = {30'd0, six[5], six[0]};
            col = {28'd0, six[4:1]};
            s[31-4*j -: 4] = 4'(SB[j][row*16+col]);
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    logic [63:0] dp_data, dp_key, dp_out;
    logic [31:0] dp_l, dp_r;
    logic [27:0] dp_c, dp_d;

    always @(posedge clk) begin : datapath
        logic [63:0] lr;
        logic [27:0] c2, d2;
        if (bus_if.ld_en) begin
            lr = ip_fn(dp_data);
            dp_l <= lr[63:32];
            dp_r <= lr[31:0];
            {dp_c, dp_d} <= pc1_fn(dp_key);
        end
        if (bus_if.rnd_en) begin
            c2 = rot_fn(dp_c, int'(bus_if.key_shift), bus_if.key_dir);
            d2 = rot_fn(dp_d, int'(bus_if.key_shift), bus_if.key_dir);
            dp_c <= c2;
            dp_d <= d2;
            dp_l <= dp_r;
            dp_r <= dp_l ^ f_fn(dp_r, pc2_fn({c2, d2}));
        end
        if (bus_if.fin_en) dp_out <= fp_fn({dp_r, dp_l});
    end

    // Reference: phase counts cycles since the accept edge; everything else follows from it.
    bit m_busy;
    int m_p;
    bit m_mode;
    int m_last_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit e_rnd, e_fin, e_out;
        int e_idx, e_shift;
        @(negedge clk);
        e_rnd   = m_busy && m_p >= 1 && m_p <= NR;
        e_fin   = m_busy && m_p == NR + 1;
        e_out   = m_busy && m_p >= NR + 2;
        e_idx   = !m_busy ? m_last_idx : (m_p <= NR ? m_p - 1 : NR - 1);
        e_shift = e_rnd ? (m_mode ? dec_tbl[m_p-1] : enc_tbl[m_p-1]) : 0;
        check("in_ready",  64'(bus_if.in_ready),  64'(!m_busy));
        check("busy",      64'(bus_if.busy),      64'(m_busy));
        check("ld_en",     64'(bus_if.ld_en),     64'(!m_busy && bus_if.in_valid));
        check("rnd_en",    64'(bus_if.rnd_en),    64'(e_rnd));
        check("fin_en",    64'(bus_if.fin_en),    64'(e_fin));
        check("out_valid", 64'(bus_if.out_valid), 64'(e_out));
        check("rnd_idx",   64'(bus_if.rnd_idx),   64'(e_idx));
        check("key_shift", 64'(bus_if.key_shift), 64'(e_shift));
        check("key_dir",   64'(bus_if.key_dir),   64'(m_mode));
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_mode = 1'b0; m_last_idx = 0;
        end else if (!m_busy) begin
            if (bus_if.in_valid) begin
                m_busy = 1'b1; m_p = 1; m_mode = bus_if.in_decrypt; m_last_idx = 0;
            end
        end else if (m_p >= NR + 2) begin
            if (bus_if.out_ready) begin
                m_busy = 1'b0; m_last_idx = NR - 1;
            end
        end else begin
            m_p++;
        end
        #1;
    endtask

    task automatic run_block(input bit dec, input logic [63:0] data, output logic [63:0] res);
        int n;
        dp_data = data;
        bus_if.in_decrypt = dec;
        bus_if.out_ready  = 1'b1;
        bus_if.in_valid   = 1'b1;
        step();
        bus_if.in_valid   = 1'b0;
        bus_if.in_decrypt = ~dec;
        n = 0;
        while (!bus_if.out_valid && n < 40) begin
            step();
            n++;
        end
        check("out_valid_timeout", 64'(bus_if.out_valid), 64'd1);
        step();
        res = dp_out;
    endtask

    initial begin
        logic [63:0] res, pt, ct;
        rst = 1'b1;
        bus_if.in_valid = 1'b0; bus_if.in_decrypt = 1'b0; bus_if.out_ready = 1'b0;
        dp_data = '0; dp_key = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_mode = 1'b0; m_last_idx = 0; m_p = 0;
        repeat (10) step();

        dp_key = 64'h133457799BBCDFF1;
        run_block(1'b0, 64'h0123456789ABCDEF, res);
        check("des_encrypt", res, 64'h85E813540F0AB405);
        step();
        run_block(1'b1, 64'h85E813540F0AB405, res);
        check("des_decrypt", res, 64'h0123456789ABCDEF);
        step();

        // backpressure with a waiting request
        bus_if.in_decrypt = 1'b0; bus_if.out_ready = 1'b0; bus_if.in_valid = 1'b1;
        step();
        repeat (NR + 1) step();
        repeat (5) step();
        bus_if.out_ready = 1'b1;
        step();
        step();
        bus_if.in_valid = 1'b0;
        repeat (NR + 2) step();
        step();

        // abort on reset in the round with index 7
        bus_if.in_decrypt = 1'b1; bus_if.in_valid = 1'b1;
        step();
        bus_if.in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();

        // random round trips through the datapath
        for (int t = 0; t < 3; t++) begin
            dp_key = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            run_block(1'b0, pt, ct);
            run_block(1'b1, ct, res);
            check("des_roundtrip", res, pt);
        end

        // random handshake and reset traffic
        for (int t = 0; t < 600; t++) begin
            bus_if.in_valid   = ($urandom_range(0, 3) != 0);
            bus_if.in_decrypt = $urandom_range(0, 1) == 1;
            bus_if.out_ready  = $urandom_range(0, 1) == 1;
            rst               = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
